// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - two-requester arbiter in front of the single-port data RAM
//
// Shares one single-port RAM between the core load/store port and the host
// loader/dumper port. One access is granted per cycle. A round-robin priority
// bit resolves contention. The host may hold the RAM for a bounded run of
// consecutive accesses by raising host_lock_i. Core byte addresses are checked
// for alignment and range; bad accesses are granted but never reach the RAM.
//
// Ports:
//   clock_i, reset_i        clock, synchronous active-high reset
//   core_req_i .. _wdata_i  core request: load/store, byte address, store data
//   core_gnt_o              core access accepted this cycle
//   core_rvalid_o/_rdata_o  core load data, one cycle after a load grant
//   core_err_o              pulse in the grant cycle of a bad core access
//   host_req_i .. _wdata_i  host request: read/write, lock, word address, data
//   host_gnt_o              host access accepted this cycle
//   host_rvalid_o/_rdata_o  host read data, one cycle after a read grant
//   ram_en_o .. ram_wdata_o RAM access strobe, write enable, word address, data
//   ram_rdata_i             RAM read data, valid the cycle after a read enable

module ram_port_arbiter #(
    parameter int DATAWIDTH = 32,
    parameter int ADDRWIDTH = 10,
    parameter int RAMDEPTH  = 1024,
    parameter int MAXLOCK   = 16
) (
    input  logic                 clock_i,
    input  logic                 reset_i,

    input  logic                 core_req_i,
    input  logic                 core_we_i,
    input  logic [31:0]          core_addr_i,
    input  logic [DATAWIDTH-1:0] core_wdata_i,
    output logic                 core_gnt_o,
    output logic                 core_rvalid_o,
    output logic [DATAWIDTH-1:0] core_rdata_o,
    output logic                 core_err_o,

    input  logic                 host_req_i,
    input  logic                 host_we_i,
    input  logic                 host_lock_i,
    input  logic [ADDRWIDTH-1:0] host_addr_i,
    input  logic [DATAWIDTH-1:0] host_wdata_i,
    output logic                 host_gnt_o,
    output logic                 host_rvalid_o,
    output logic [DATAWIDTH-1:0] host_rdata_o,

    output logic                 ram_en_o,
    output logic                 ram_we_o,
    output logic [ADDRWIDTH-1:0] ram_addr_o,
    output logic [DATAWIDTH-1:0] ram_wdata_o,
    input  logic [DATAWIDTH-1:0] ram_rdata_i
);

    localparam int LOCKW = $clog2(MAXLOCK) + 1;

    typedef enum logic {
        SIDE_CORE = 1'b0,
        SIDE_HOST = 1'b1
    } side_e;

    side_e            prio_q,    prio_d;
    logic [LOCKW-1:0] lockcnt_q, lockcnt_d;
    side_e            rsel_q,    rsel_d;
    logic             rpend_q,   rpend_d;
    logic             errpend_q, errpend_d;
    // Host owned the RAM in the previous cycle; a lock only extends a run
    // that is already in progress.
    logic             hlast_q,   hlast_d;

    logic             core_bad;
    logic             contend;
    logic             lock_full;
    logic             lock_hold;
    logic             core_win;
    logic             host_win;
    logic             core_ram;

    // The full 30-bit word index is compared so that addresses beyond the
    // ram_addr_o field are caught rather than aliased onto low words.
    assign core_bad  = (core_addr_i[1:0] != 2'b00)
                     || ({2'b00, core_addr_i[31:2]} >= 32'(RAMDEPTH));

    assign contend   = core_req_i & host_req_i;
    assign lock_full = (lockcnt_q == LOCKW'(MAXLOCK));
    assign lock_hold = hlast_q & host_lock_i & ~lock_full;

    // Winner selection. Under contention an exhausted lock forces the core,
    // a live lock keeps the host, otherwise the priority bit decides.
    always_comb begin
        core_win = 1'b0;
        host_win = 1'b0;
        if (!reset_i) begin
            if (contend) begin
                if (lock_full) begin
                    core_win = 1'b1;
                end else if (lock_hold) begin
                    host_win = 1'b1;
                end else if (prio_q == SIDE_HOST) begin
                    host_win = 1'b1;
                end else begin
                    core_win = 1'b1;
                end
            end else begin
                core_win = core_req_i;
                host_win = host_req_i;
            end
        end
    end

    assign core_ram    = core_win & ~core_bad;

    assign core_gnt_o  = core_win;
    assign host_gnt_o  = host_win;
    assign core_err_o  = core_win & core_bad;

    assign ram_en_o    = host_win | core_ram;
    assign ram_we_o    = host_win ? host_we_i : (core_ram & core_we_i);
    assign ram_addr_o  = host_win ? host_addr_i
                       : core_ram ? core_addr_i[ADDRWIDTH+1:2]
                       : '0;
    assign ram_wdata_o = host_win ? host_wdata_i
                       : core_ram ? core_wdata_i
                       : '0;

    // Read return is steered by the owner recorded at grant time, so
    // alternating owners can read back to back without cross-delivery.
    assign core_rvalid_o = ~reset_i & rpend_q & (rsel_q == SIDE_CORE);
    assign host_rvalid_o = ~reset_i & rpend_q & (rsel_q == SIDE_HOST);
    assign core_rdata_o  = (core_rvalid_o & ~errpend_q) ? ram_rdata_i : '0;
    assign host_rdata_o  = host_rvalid_o ? ram_rdata_i : '0;

    always_comb begin
        prio_d    = prio_q;
        lockcnt_d = lockcnt_q;

        // Only contended grants hand priority to the side that lost.
        if (contend && (core_win || host_win)) begin
            prio_d = core_win ? SIDE_HOST : SIDE_CORE;
        end

        // lockcnt counts the host wins that were forced by the lock.
        if (core_win || !host_lock_i) begin
            lockcnt_d = '0;
        end else if (contend && lock_hold) begin
            lockcnt_d = lockcnt_q + LOCKW'(1);
        end

        hlast_d   = host_win;
        rpend_d   = (core_win & ~core_we_i) | (host_win & ~host_we_i);
        rsel_d    = host_win ? SIDE_HOST : SIDE_CORE;
        errpend_d = core_win & ~core_we_i & core_bad;
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            prio_q    <= SIDE_CORE;
            lockcnt_q <= '0;
            rsel_q    <= SIDE_CORE;
            rpend_q   <= 1'b0;
            errpend_q <= 1'b0;
            hlast_q   <= 1'b0;
        end else begin
            prio_q    <= prio_d;
            lockcnt_q <= lockcnt_d;
            rsel_q    <= rsel_d;
            rpend_q   <= rpend_d;
            errpend_q <= errpend_d;
            hlast_q   <= hlast_d;
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb/tb_ram_port_arbiter.sv - self-checking bench for ram_port_arbiter

module tb_ram_port_arbiter;

    localparam int DW      = 32;
    localparam int AW      = 10;
    localparam int DEPTH   = 1024;
    localparam int MAXLOCK = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          core_req, core_we;
    logic [31:0]   core_addr;
    logic [DW-1:0] core_wdata;
    logic          core_gnt, core_rvalid, core_err;
    logic [DW-1:0] core_rdata;
    logic          host_req, host_we, host_lock;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata;
    logic          host_gnt, host_rvalid;
    logic [DW-1:0] host_rdata;
    logic          ram_en, ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    always #5 clk = ~clk;

    ram_port_arbiter #(
        .DATAWIDTH(DW), .ADDRWIDTH(AW), .RAMDEPTH(DEPTH), .MAXLOCK(MAXLOCK)
    ) dut (
        .clock_i(clk),             .reset_i(reset),
        .core_req_i(core_req),     .core_we_i(core_we),
        .core_addr_i(core_addr),   .core_wdata_i(core_wdata),
        .core_gnt_o(core_gnt),     .core_rvalid_o(core_rvalid),
        .core_rdata_o(core_rdata), .core_err_o(core_err),
        .host_req_i(host_req),     .host_we_i(host_we),
        .host_lock_i(host_lock),   .host_addr_i(host_addr),
        .host_wdata_i(host_wdata), .host_gnt_o(host_gnt),
        .host_rvalid_o(host_rvalid), .host_rdata_o(host_rdata),
        .ram_en_o(ram_en),         .ram_we_o(ram_we),
        .ram_addr_o(ram_addr),     .ram_wdata_o(ram_wdata),
        .ram_rdata_i(ram_rdata)
    );

    // Environment RAM, driven only by the DUT's RAM port.
    logic [DW-1:0] ram [DEPTH] = '{default: '0};
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) ram[ram_addr] <= ram_wdata;
            else        ram_rdata     <= ram[ram_addr];
        end
    end

    // Reference model state: expected memory contents, priority owner,
    // length of the current lock-forced host run, and the read due next cycle.
    logic [DW-1:0] ref_mem [DEPTH] = '{default: '0};
    int            m_prio;     // 0 core, 1 host
    int            m_lockrun;
    bit            m_hlast;
    int            m_rown;     // 0 none, 1 core, 2 host
    logic [DW-1:0] m_rdata;

    int n_cmp  = 0;
    int n_fail = 0;

    // Values sampled by the most recent tick, for scenario-level checks.
    bit            obs_cg, obs_hg, obs_err, obs_en, obs_crv, obs_hrv, obs_any;
    logic [AW-1:0] obs_addr;
    logic [DW-1:0] obs_crd, obs_hrd;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_prio    = 0;
        m_lockrun = 0;
        m_hlast   = 0;
        m_rown    = 0;
        m_rdata   = '0;
    endtask

    // One clock cycle: inputs already driven; predict, sample at negedge, advance.
    task automatic tick();
        int            winner;
        bit            lockwin, c_bad, e_cg, e_hg, e_en, e_we, e_crv, e_hrv;
        logic [AW-1:0] cidx, e_addr;
        logic [DW-1:0] e_wd, e_crd, e_hrd;

        winner  = 0;
        lockwin = 0;
        cidx    = core_addr[AW+1:2];
        c_bad   = (core_addr[1:0] != 2'b00) || ((core_addr >> 2) >= 32'(DEPTH));
        if (!reset) begin
            if (core_req && host_req) begin
                if (m_lockrun == MAXLOCK)          winner = 1;
                else if (m_hlast && host_lock) begin winner = 2; lockwin = 1; end
                else                               winner = (m_prio == 1) ? 2 : 1;
            end else if (core_req) winner = 1;
            else if (host_req)     winner = 2;
        end
        e_cg   = (winner == 1);
        e_hg   = (winner == 2);
        e_en   = e_hg || (e_cg && !c_bad);
        e_we   = e_en && (e_hg ? host_we : core_we);
        e_addr = e_hg ? host_addr : cidx;
        e_wd   = e_hg ? host_wdata : core_wdata;
        e_crv  = !reset && (m_rown == 1);
        e_hrv  = !reset && (m_rown == 2);
        e_crd  = e_crv ? m_rdata : '0;
        e_hrd  = e_hrv ? m_rdata : '0;

        @(negedge clk);
        obs_cg   = core_gnt;   obs_hg  = host_gnt;   obs_err = core_err;
        obs_en   = ram_en;     obs_addr = ram_addr;
        obs_crv  = core_rvalid; obs_crd = core_rdata;
        obs_hrv  = host_rvalid; obs_hrd = host_rdata;
        obs_any  = |{core_gnt, host_gnt, core_err, core_rvalid, core_rdata,
                     host_rvalid, host_rdata, ram_en, ram_we, ram_addr, ram_wdata};

        check("core_gnt",    core_gnt,    e_cg);
        check("host_gnt",    host_gnt,    e_hg);
        check("core_err",    core_err,    e_cg && c_bad);
        check("ram_en",      ram_en,      e_en);
        check("ram_we",      ram_we,      e_we);
        if (e_en)         check("ram_addr",  ram_addr,  e_addr);
        if (e_en && e_we) check("ram_wdata", ram_wdata, e_wd);
        check("core_rvalid", core_rvalid, e_crv);
        check("core_rdata",  core_rdata,  e_crd);
        check("host_rvalid", host_rvalid, e_hrv);
        check("host_rdata",  host_rdata,  e_hrd);
        if (reset) check("reset_quiet", obs_any, 1'b0);

        if (reset) begin
            model_reset();
        end else begin
            if (core_req && host_req) m_prio = e_cg ? 1 : 0;
            if (e_cg || !host_lock)   m_lockrun = 0;
            else if (lockwin)         m_lockrun++;
            m_hlast = e_hg;
            m_rown  = 0;
            if (e_en && e_we) ref_mem[e_addr] = e_wd;
            if (e_hg && !host_we) begin m_rown = 2; m_rdata = ref_mem[host_addr]; end
            if (e_cg && !core_we) begin m_rown = 1; m_rdata = c_bad ? '0 : ref_mem[cidx]; end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reset = 0; core_req = 0; core_we = 0; host_req = 0; host_we = 0; host_lock = 0;
    endtask

    task automatic host_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        idle(); host_req = 1; host_we = 1; host_addr = a; host_wdata = d;
        tick();
    endtask

    initial begin
        int            hrun, run_res;
        bit            seen_core, done, both;
        logic [3:0]    pat;

        model_reset();
        idle();
        core_addr = '0; core_wdata = '0; host_addr = '0; host_wdata = '0;
        @(posedge clk); #1;

        // Reset with requests asserted: everything must stay quiet.
        reset = 1; core_req = 1; host_req = 1;
        tick(); tick();

        // Preload through the host port.
        host_write(10'd4, 32'd123);
        host_write(10'd5, 32'd7);
        host_write(10'd6, 32'd9);

        // Core load from byte 0x10 -> word 4.
        idle(); core_req = 1; core_addr = 32'h10;
        tick();
        check("t1_gnt",  obs_cg,   1'b1);
        check("t1_addr", obs_addr, 10'd4);
        idle(); tick();
        check("t1_rvalid", obs_crv, 1'b1);
        check("t1_rdata",  obs_crd, 32'd123);

        // Sustained contention after reset alternates core, host, core, host.
        idle(); reset = 1; tick();
        idle(); core_req = 1; host_req = 1; core_addr = 32'h20; host_addr = 10'd3;
        pat = '0; both = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            pat  = {pat[2:0], obs_cg};
            both = both | (obs_cg & obs_hg);
        end
        check("t2_pattern", pat,  4'b1010);
        check("t2_both",    both, 1'b0);

        // Host lock: after the first core grant, the host keeps the RAM for
        // one ordinary grant plus MAXLOCK locked grants before the core returns.
        idle(); reset = 1; tick();
        idle(); core_req = 1; core_we = 1; core_addr = 32'h40; core_wdata = 32'hC0DE;
        host_req = 1; host_we = 1; host_lock = 1; host_addr = 10'd100;
        hrun = 0; run_res = -1; seen_core = 0; done = 0;
        for (int i = 0; i < 40; i++) begin
            host_wdata = $urandom;
            tick();
            if (!done) begin
                if (obs_cg) begin
                    if (seen_core) begin run_res = hrun; done = 1; end
                    seen_core = 1;
                    hrun = 0;
                end else if (obs_hg) begin
                    hrun++;
                end
            end
        end
        check("t3_hostrun", run_res, MAXLOCK + 1);

        // Misaligned store and out-of-range load.
        idle(); core_req = 1; core_we = 1; core_addr = 32'h13; core_wdata = 32'hDEAD;
        tick();
        check("t4_st_err", obs_err, 1'b1);
        check("t4_st_en",  obs_en,  1'b0);
        idle(); core_req = 1; core_addr = 32'(4 * DEPTH);
        tick();
        check("t4_ld_err", obs_err, 1'b1);
        check("t4_ld_en",  obs_en,  1'b0);
        idle(); tick();
        check("t4_rvalid", obs_crv, 1'b1);
        check("t4_rdata",  obs_crd, 32'd0);
        check("t4_ram4",   ram[4],  32'd123);

        // Host read then core read in consecutive cycles.
        idle(); host_req = 1; host_addr = 10'd5;
        tick();
        idle(); core_req = 1; core_addr = 32'h18;
        tick();
        check("t5_h_rvalid", obs_hrv, 1'b1);
        check("t5_h_rdata",  obs_hrd, 32'd7);
        check("t5_h_cross",  obs_crv, 1'b0);
        idle(); tick();
        check("t5_c_rvalid", obs_crv, 1'b1);
        check("t5_c_rdata",  obs_crd, 32'd9);
        check("t5_c_cross",  obs_hrv, 1'b0);

        // Load granted, then reset before its data returns.
        idle(); core_req = 1; core_addr = 32'h10;
        tick();
        reset = 1; core_req = 1; host_req = 1;
        tick();
        check("t6_quiet", obs_any, 1'b0);
        idle(); core_req = 1; host_req = 1; core_addr = 32'h24; host_addr = 10'd1;
        tick();
        check("t6_prio", obs_cg, 1'b1);

        // Random traffic against the reference model.
        for (int i = 0; i < 600; i++) begin
            reset     = ($urandom_range(63) == 0);
            core_req  = $urandom_range(1);
            core_we   = $urandom_range(1);
            core_wdata = $urandom;
            case ($urandom_range(7))
                0:       core_addr = {20'h0, 10'($urandom_range(DEPTH - 1)), 2'($urandom_range(1, 3))};
                1:       core_addr = 32'($urandom_range(DEPTH, 4 * DEPTH)) << 2;
                default: core_addr = {20'h0, 10'($urandom_range(DEPTH - 1)), 2'b00};
            endcase
            host_req   = $urandom_range(1);
            host_we    = $urandom_range(1);
            host_lock  = ($urandom_range(3) != 0);
            host_addr  = 10'($urandom_range(DEPTH - 1));
            host_wdata = $urandom;
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares the single-port data RAM between two requesters: the riscv32s core load/store port and a host port.
- The host port is the FPGA loader/dumper that preloads JPEG input words and reads back results after the core halts.
- Sits between core, host and ram; all ram accesses pass through it.
- Arbitrates per access, round-robin under contention, with an optional bounded host burst lock and address checking on the core side.

Parameters:
- DATAWIDTH, 32, data word width.
- ADDRWIDTH, 10, RAM word-address width.
- RAMDEPTH, 1024, number of valid words; must be <= 2**ADDRWIDTH.
- MAXLOCK, 16, maximum consecutive host grants under host_lock while core_req is pending.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- core_req  in  1  core access request; held until core_gnt.
- core_we  in  1  1 = store, 0 = load.
- core_addr  in  32  byte address; word index = core_addr[ADDRWIDTH+1:2].
- core_wdata  in  DATAWIDTH  store data.
- core_gnt  out  1  access accepted this cycle.
- core_rvalid  out  1  load data valid (one cycle after a load grant).
- core_rdata  out  DATAWIDTH  load data.
- core_err  out  1  one-cycle pulse: misaligned or out-of-range access.
- host_req  in  1  host access request.
- host_we  in  1  1 = write.
- host_lock  in  1  request to keep the grant for consecutive accesses.
- host_addr  in  ADDRWIDTH  word address.
- host_wdata  in  DATAWIDTH  write data.
- host_gnt  out  1  access accepted.
- host_rvalid  out  1  read data valid.
- host_rdata  out  DATAWIDTH  read data.
- ram_en  out  1  ram access enable.
- ram_we  out  1  ram write enable.
- ram_addr  out  ADDRWIDTH  ram word address.
- ram_wdata  out  DATAWIDTH  ram write data.
- ram_rdata  in  DATAWIDTH  ram read data, valid the cycle after a read enable.

Behaviour:
- Grant path: core_gnt, host_gnt, ram_en, ram_we, ram_addr and ram_wdata are combinational from the requests and registered state.
- One grant per cycle maximum; core_gnt and host_gnt are never both 1.
- Registered state:
  - prio: 0 = core, 1 = host.
  - lockcnt: log2(MAXLOCK)+1 bits.
  - rsel: pending read owner.
  - rpend: a read is outstanding.
  - errpend: the outstanding core load is erroneous.
- Arbitration:
  - Single requester: that requester is granted.
  - Both requesting: the prio side wins.
  - After a contended grant, prio flips to the loser.
  - Uncontended grants leave prio unchanged.
- Host lock:
  - If the host was granted last cycle, host_lock=1 and lockcnt < MAXLOCK, the host wins contention and lockcnt increments.
  - When lockcnt == MAXLOCK, the core wins the next contention and lockcnt clears.
  - lockcnt also clears on any core grant or when host_lock=0.
- Core address check:
  - Error if core_addr[1:0] != 0 or word index >= RAMDEPTH.
  - An erroneous granted core access still asserts core_gnt but suppresses ram_en and ram_we.
  - core_err pulses in the grant cycle.
  - An erroneous load still returns core_rvalid next cycle with core_rdata = 0.
  - An erroneous store is dropped.
- Read return:
  - On a granted load, rpend <= 1 and rsel <= owner.
  - Next cycle, the owner's rvalid = 1 and its rdata = ram_rdata (or 0 if errpend).
  - The non-owner's rdata is held at 0.
  - Back-to-back reads from alternating owners are allowed: throughput is one access per cycle and read latency is always 1.
- Writes: complete in the grant cycle; no rvalid.
- Reset:
  - All outputs 0, prio=0, lockcnt=0, rpend=0, errpend=0.
  - A read granted in the cycle reset is asserted produces no rvalid.
  - Requests are ignored while reset=1.
- A requester that drops req without receiving a grant is legal; nothing is recorded.

Test Plan:
- Core load only, core_addr=0x10, ram[4]=123 → core_gnt same cycle, ram_addr=4, next cycle core_rvalid=1, core_rdata=123.
- core_req and host_req held high together for 4 cycles after reset → grants core, host, core, host; never both high.
- host_lock=1, continuous host writes, core_req held from cycle 0, MAXLOCK=16 → the host's last grant before lock engagement is followed by 16 host grants, then core_gnt; core waits at most MAXLOCK+1 cycles.
- Core store to 0x13 (misaligned), then load from 4*RAMDEPTH → core_err pulses both times, ram_en=0 both times, load returns core_rvalid=1 with rdata=0, RAM unchanged.
- Host reads addr 5 and then core reads addr 6 in consecutive cycles, ram[5]=7, ram[6]=9 → host_rvalid=1/host_rdata=7, then core_rvalid=1/core_rdata=9, with no cross-delivery.
- Core load granted, reset asserted the next cycle → core_rvalid=0 and all outputs 0 during reset; prio=core afterwards.
